// File: rtl/vend_controller_multi.sv
`default_nettype none
// ============================================================================
// Module   : vend_controller_multi
// Purpose  : Multi-product vending controller. Holds a runtime-loadable table
//            of NUM_SLOTS (code, price) entries, validates keypad codes
//            against it, accumulates coin credit, issues a vend pulse and
//            refunds change. Supports cancel and an inactivity timeout.
//
// Optional : `define STOCK_COUNT_EN adds a per-slot stock counter, the
//            cfg_stock port and the sold_out pulse. Without it stock is
//            unlimited, cfg_stock is absent and sold_out is tied low.
//
// Ports    : clk, reset        - clock, synchronous active-high reset
//            code/code_ready   - keypad code and its one-cycle strobe
//            coin/coin_ready   - coin value (cents) and its strobe
//            cancel            - abort the current purchase
//            cfg_we/cfg_idx/cfg_code/cfg_price[/cfg_stock]
//                              - table write port (IDLE only)
//            busy, code_valid  - status levels
//            code_invalid, sold_out, coin_reject, timeout_flag
//                              - one-cycle event pulses
//            credit, price     - current credit and selection price
//            vend/vend_slot    - dispense pulse and slot index
//            refund_valid/usd_refund - refund pulse and amount
//
// Revision : 1.0 - initial release
// ============================================================================
module vend_controller_multi #(
    parameter int NUM_SLOTS   = 8,
    parameter int CODE_W      = 8,
    parameter int MONEY_W     = 12,
    parameter int TIMEOUT_CYC = 1000,
    parameter int STOCK_W     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CODE_W-1:0]            code,
    input  logic                         code_ready,
    input  logic [MONEY_W-1:0]           coin,
    input  logic                         coin_ready,
    input  logic                         cancel,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_SLOTS)-1:0] cfg_idx,
    input  logic [CODE_W-1:0]            cfg_code,
    input  logic [MONEY_W-1:0]           cfg_price,
`ifdef STOCK_COUNT_EN
    input  logic [STOCK_W-1:0]           cfg_stock,
`endif
    output logic                         busy,
    output logic                         code_valid,
    output logic                         code_invalid,
    output logic                         sold_out,
    output logic                         coin_reject,
    output logic [MONEY_W-1:0]           credit,
    output logic [MONEY_W-1:0]           price,
    output logic                         vend,
    output logic [$clog2(NUM_SLOTS)-1:0] vend_slot,
    output logic                         refund_valid,
    output logic [MONEY_W-1:0]           usd_refund,
    output logic                         timeout_flag
);

    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_PAY    = 2'd1;
    localparam logic [1:0] c_ST_VEND   = 2'd2;
    localparam logic [1:0] c_ST_REFUND = 2'd3;

    localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [IDX_W-1:0]   r_slot;
    logic [MONEY_W-1:0] r_price;
    logic [MONEY_W-1:0] r_credit;
    logic [MONEY_W-1:0] r_amount;
    logic [TMR_W-1:0]   r_timer;
    logic               r_code_invalid;
    logic               r_sold_out;
    logic               r_coin_reject;
    logic               r_timeout_flag;

    logic [CODE_W-1:0]  r_tbl_code  [NUM_SLOTS];
    logic [MONEY_W-1:0] r_tbl_price [NUM_SLOTS];

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic               w_hit;
    logic [IDX_W-1:0]   w_hit_idx;
    logic               w_hit_empty;
    logic [MONEY_W:0]   w_coin_sum;
    logic [MONEY_W-1:0] w_credit_add;
    logic [MONEY_W-1:0] w_change;
    logic               w_cfg_accept;

    // Scan from the top down so the lowest matching enabled index is the
    // last assignment and therefore wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if ((r_tbl_price[i] != '0) && (r_tbl_code[i] == code)) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    // One extra bit catches the carry so credit saturates instead of wrapping.
    assign w_coin_sum   = {1'b0, r_credit} + {1'b0, coin};
    assign w_credit_add = w_coin_sum[MONEY_W] ? {MONEY_W{1'b1}} : w_coin_sum[MONEY_W-1:0];

    // Only evaluated in VEND, where credit >= price is guaranteed.
    assign w_change = r_credit - r_price;

    // A write racing a lookup is dropped so the lookup sees a stable table.
    assign w_cfg_accept = cfg_we && !code_ready && (r_state == c_ST_IDLE)
                          && (32'(cfg_idx) < NUM_SLOTS);

    // ------------------------------------------------------------------------
    // Product table
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_tbl_code[i]  <= '0;
                r_tbl_price[i] <= '0;
            end
        end else if (w_cfg_accept) begin
            r_tbl_code[cfg_idx]  <= cfg_code;
            r_tbl_price[cfg_idx] <= cfg_price;
        end
    end

`ifdef STOCK_COUNT_EN
    logic [STOCK_W-1:0] r_tbl_stock [NUM_SLOTS];

    // Loads only happen in IDLE and decrements only in VEND, so the two
    // updates never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_tbl_stock[i] <= '0;
            end
        end else if (w_cfg_accept) begin
            r_tbl_stock[cfg_idx] <= cfg_stock;
        end else if ((r_state == c_ST_VEND) && (r_tbl_stock[r_slot] != '0)) begin
            r_tbl_stock[r_slot] <= r_tbl_stock[r_slot] - 1'b1;
        end
    end

    assign w_hit_empty = w_hit && (r_tbl_stock[w_hit_idx] == '0);
`else
    assign w_hit_empty = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Purchase FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_ST_IDLE;
            r_slot         <= '0;
            r_price        <= '0;
            r_credit       <= '0;
            r_amount       <= '0;
            r_timer        <= '0;
            r_code_invalid <= 1'b0;
            r_sold_out     <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_timeout_flag <= 1'b0;
        end else begin
            r_code_invalid <= 1'b0;
            r_sold_out     <= 1'b0;
            r_timeout_flag <= 1'b0;
            r_coin_reject  <= coin_ready && (r_state != c_ST_PAY);

            case (r_state)
                c_ST_IDLE: begin
                    if (code_ready) begin
                        if (w_hit && !w_hit_empty) begin
                            r_state  <= c_ST_PAY;
                            r_price  <= r_tbl_price[w_hit_idx];
                            r_slot   <= w_hit_idx;
                            r_credit <= '0;
                            r_timer  <= '0;
                        end else begin
                            r_code_invalid <= 1'b1;
                            r_sold_out     <= w_hit_empty;
                        end
                    end
                end

                c_ST_PAY: begin
                    if (coin_ready) begin
                        r_credit <= w_credit_add;
                        r_timer  <= '0;
                        // A sufficient coin completes the sale even if cancel
                        // arrives in the same cycle.
                        if (w_credit_add >= r_price) begin
                            r_state <= c_ST_VEND;
                        end else if (cancel) begin
                            r_state  <= c_ST_REFUND;
                            r_amount <= w_credit_add;
                        end
                    end else if (cancel) begin
                        r_state  <= c_ST_REFUND;
                        r_amount <= r_credit;
                    end else if (r_timer == c_TMR_LAST) begin
                        r_state        <= c_ST_REFUND;
                        r_amount       <= r_credit;
                        r_timeout_flag <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                c_ST_VEND: begin
                    if (w_change != '0) begin
                        r_state  <= c_ST_REFUND;
                        r_amount <= w_change;
                    end else begin
                        r_state  <= c_ST_IDLE;
                        r_credit <= '0;
                        r_price  <= '0;
                    end
                end

                c_ST_REFUND: begin
                    r_state  <= c_ST_IDLE;
                    r_credit <= '0;
                    r_price  <= '0;
                    r_amount <= '0;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: all decoded straight from registers
    // ------------------------------------------------------------------------
    assign busy         = (r_state != c_ST_IDLE);
    assign code_valid   = (r_state == c_ST_PAY) || (r_state == c_ST_VEND);
    assign vend         = (r_state == c_ST_VEND);
    assign vend_slot    = vend ? r_slot : '0;
    assign refund_valid = (r_state == c_ST_REFUND);
    assign usd_refund   = refund_valid ? r_amount : '0;
    assign credit       = r_credit;
    assign price        = r_price;
    assign code_invalid = r_code_invalid;
    assign sold_out     = r_sold_out;
    assign coin_reject  = r_coin_reject;
    assign timeout_flag = r_timeout_flag;

endmodule
`default_nettype wire

// File: tb/tb_vend_controller_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_controller_multi
// Purpose  : Self-checking bench for vend_controller_multi. Scenario tasks
//            drive stimulus, push the expected event pulses to a queue and
//            check levels inline; a negedge monitor pops and compares every
//            pulse the controller produces.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vend_controller_multi;

    localparam int NUM_SLOTS   = 8;
    localparam int CODE_W      = 8;
    localparam int MONEY_W     = 12;
    localparam int TIMEOUT_CYC = 20;
    localparam int STOCK_W     = 4;
    localparam int IDX_W       = $clog2(NUM_SLOTS);

    localparam logic [3:0] EV_INVALID = 4'd1;
    localparam logic [3:0] EV_SOLDOUT = 4'd2;
    localparam logic [3:0] EV_REJECT  = 4'd3;
    localparam logic [3:0] EV_VEND    = 4'd4;
    localparam logic [3:0] EV_REFUND  = 4'd5;
    localparam logic [3:0] EV_TIMEOUT = 4'd6;

    typedef struct packed {
        logic [3:0]  kind;
        logic [15:0] val;
    } ev_t;

    logic               clk;
    logic               reset;
    logic [CODE_W-1:0]  code;
    logic               code_ready;
    logic [MONEY_W-1:0] coin;
    logic               coin_ready;
    logic               cancel;
    logic               cfg_we;
    logic [IDX_W-1:0]   cfg_idx;
    logic [CODE_W-1:0]  cfg_code;
    logic [MONEY_W-1:0] cfg_price;
    logic [STOCK_W-1:0] cfg_stock;
    logic               busy;
    logic               code_valid;
    logic               code_invalid;
    logic               sold_out;
    logic               coin_reject;
    logic [MONEY_W-1:0] credit;
    logic [MONEY_W-1:0] price;
    logic               vend;
    logic [IDX_W-1:0]   vend_slot;
    logic               refund_valid;
    logic [MONEY_W-1:0] usd_refund;
    logic               timeout_flag;

    int  n_checks = 0;
    int  n_errors = 0;
    ev_t exp_q[$];
    ev_t mon_obs[$];
    ev_t mon_exp;

    vend_controller_multi #(
        .NUM_SLOTS   (NUM_SLOTS),
        .CODE_W      (CODE_W),
        .MONEY_W     (MONEY_W),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .STOCK_W     (STOCK_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .code         (code),
        .code_ready   (code_ready),
        .coin         (coin),
        .coin_ready   (coin_ready),
        .cancel       (cancel),
        .cfg_we       (cfg_we),
        .cfg_idx      (cfg_idx),
        .cfg_code     (cfg_code),
        .cfg_price    (cfg_price),
`ifdef STOCK_COUNT_EN
        .cfg_stock    (cfg_stock),
`endif
        .busy         (busy),
        .code_valid   (code_valid),
        .code_invalid (code_invalid),
        .sold_out     (sold_out),
        .coin_reject  (coin_reject),
        .credit       (credit),
        .price        (price),
        .vend         (vend),
        .vend_slot    (vend_slot),
        .refund_valid (refund_valid),
        .usd_refund   (usd_refund),
        .timeout_flag (timeout_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: every event pulse must match the next expected entry.
    always @(negedge clk) begin
        if (!reset) begin
            mon_obs.delete();
            if (code_invalid) mon_obs.push_back('{EV_INVALID, 16'd0});
            if (sold_out)     mon_obs.push_back('{EV_SOLDOUT, 16'd0});
            if (coin_reject)  mon_obs.push_back('{EV_REJECT, 16'd0});
            if (vend)         mon_obs.push_back('{EV_VEND, 16'(vend_slot)});
            if (refund_valid) mon_obs.push_back('{EV_REFUND, 16'(usd_refund)});
            if (timeout_flag) mon_obs.push_back('{EV_TIMEOUT, 16'd0});
            foreach (mon_obs[k]) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL scoreboard_unexpected: got kind=%0d val=%0d, required no event at %0t",
                             mon_obs[k].kind, mon_obs[k].val, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_obs[k] !== mon_exp) begin
                        n_errors++;
                        $display("FAIL scoreboard_event: got kind=%0d val=%0d, required kind=%0d val=%0d at %0t",
                                 mon_obs[k].kind, mon_obs[k].val, mon_exp.kind, mon_exp.val, $time);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (drive only)
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input logic [3:0] k, input int v);
        exp_q.push_back('{k, 16'(v)});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic cfg_write(input int idx, input int c, input int p, input int s);
        cfg_we    = 1'b1;
        cfg_idx   = IDX_W'(idx);
        cfg_code  = CODE_W'(c);
        cfg_price = MONEY_W'(p);
        cfg_stock = STOCK_W'(s);
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic send_code(input int c);
        code       = CODE_W'(c);
        code_ready = 1'b1;
        step();
        code_ready = 1'b0;
    endtask

    task automatic send_coin(input int v, input logic with_cancel);
        coin       = MONEY_W'(v);
        coin_ready = 1'b1;
        cancel     = with_cancel;
        step();
        coin_ready = 1'b0;
        cancel     = 1'b0;
    endtask

    task automatic send_cancel();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        n_checks++;
        if ({busy, code_valid, code_invalid, sold_out, coin_reject, vend, refund_valid, timeout_flag} !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_flags: got %b, required 00000000",
                     {busy, code_valid, code_invalid, sold_out, coin_reject, vend, refund_valid, timeout_flag});
        end
        n_checks++;
        if ({credit, price, usd_refund} !== '0 || vend_slot !== '0) begin
            n_errors++;
            $display("FAIL reset_values: got credit=%0d price=%0d refund=%0d slot=%0d, required all 0",
                     credit, price, usd_refund, vend_slot);
        end
        reset = 1'b0;
        // Cleared table: even code 0x00 (reset code value) must be invalid.
        push_ev(EV_INVALID, 0);
        send_code(8'h00);
        n_checks++;
        if (code_invalid !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_table_cleared: got invalid=%b busy=%b, required invalid=1 busy=0",
                     code_invalid, busy);
        end
        step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL reset_pending: got %0d pending events, required 0", exp_q.size());
        end
    endtask

    task automatic test_basic_purchase();
        cfg_write(0, 8'hA1, 100, 15);
        send_code(8'hA1);
        n_checks++;
        if (code_valid !== 1'b1 || busy !== 1'b1 || price !== 12'd100 || credit !== 12'd0) begin
            n_errors++;
            $display("FAIL basic_select: got valid=%b busy=%b price=%0d credit=%0d, required 1 1 100 0",
                     code_valid, busy, price, credit);
        end
        send_coin(25, 1'b0);
        n_checks++;
        if (credit !== 12'd25 || vend !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_credit25: got credit=%0d vend=%b, required 25 0", credit, vend);
        end
        send_coin(25, 1'b0);
        n_checks++;
        if (credit !== 12'd50 || vend !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_credit50: got credit=%0d vend=%b, required 50 0", credit, vend);
        end
        push_ev(EV_VEND, 0);
        send_coin(50, 1'b0);
        n_checks++;
        if (vend !== 1'b1 || vend_slot !== 3'd0 || credit !== 12'd100 || code_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_vend: got vend=%b slot=%0d credit=%0d valid=%b, required 1 0 100 1",
                     vend, vend_slot, credit, code_valid);
        end
        step();
        n_checks++;
        if (busy !== 1'b0 || refund_valid !== 1'b0 || code_valid !== 1'b0 || credit !== 12'd0) begin
            n_errors++;
            $display("FAIL basic_idle: got busy=%b refund=%b valid=%b credit=%0d, required 0 0 0 0",
                     busy, refund_valid, code_valid, credit);
        end
        step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL basic_pending: got %0d pending events, required 0", exp_q.size());
        end
    endtask

    task automatic test_change();
        cfg_write(3, 8'hB1, 125, 15);
        send_code(8'hB1);
        push_ev(EV_VEND, 3);
        push_ev(EV_REFUND, 75);
        send_coin(200, 1'b0);
        n_checks++;
        if (vend !== 1'b1 || vend_slot !== 3'd3) begin
            n_errors++;
            $display("FAIL change_vend: got vend=%b slot=%0d, required 1 3", vend, vend_slot);
        end
        step();
        n_checks++;
        if (refund_valid !== 1'b1 || usd_refund !== 12'd75 || code_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL change_refund: got refund=%b amount=%0d valid=%b, required 1 75 0",
                     refund_valid, usd_refund, code_valid);
        end
        step();
        step();
        n_checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL change_end: got busy=%b pending=%0d, required 0 0", busy, exp_q.size());
        end
    endtask

    task automatic test_invalid_reject();
        do_reset();
        push_ev(EV_INVALID, 0);
        send_code(8'hFF);
        n_checks++;
        if (code_invalid !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL invalid_pulse: got invalid=%b busy=%b, required 1 0", code_invalid, busy);
        end
        step();
        n_checks++;
        if (code_invalid !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL invalid_single: got invalid=%b busy=%b, required 0 0", code_invalid, busy);
        end
        push_ev(EV_REJECT, 0);
        send_coin(25, 1'b0);
        n_checks++;
        if (coin_reject !== 1'b1 || credit !== 12'd0) begin
            n_errors++;
            $display("FAIL reject_idle: got reject=%b credit=%0d, required 1 0", coin_reject, credit);
        end
        step();
        step();
        n_checks++;
        if (coin_reject !== 1'b0 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL reject_end: got reject=%b pending=%0d, required 0 0", coin_reject, exp_q.size());
        end
    endtask

    task automatic test_cancel();
        cfg_write(1, 8'h75, 75, 15);
        send_code(8'h75);
        send_coin(50, 1'b0);
        push_ev(EV_REFUND, 50);
        send_cancel();
        n_checks++;
        if (refund_valid !== 1'b1 || usd_refund !== 12'd50 || code_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL cancel_refund: got refund=%b amount=%0d valid=%b, required 1 50 0",
                     refund_valid, usd_refund, code_valid);
        end
        step();
        n_checks++;
        if (busy !== 1'b0 || credit !== 12'd0) begin
            n_errors++;
            $display("FAIL cancel_idle: got busy=%b credit=%0d, required 0 0", busy, credit);
        end
        // Zero credit cancel still pulses a refund of 0.
        send_code(8'h75);
        push_ev(EV_REFUND, 0);
        send_cancel();
        n_checks++;
        if (refund_valid !== 1'b1 || usd_refund !== 12'd0) begin
            n_errors++;
            $display("FAIL cancel_zero: got refund=%b amount=%0d, required 1 0", refund_valid, usd_refund);
        end
        step();
        // Cancel with an insufficient coin refunds the coin as well.
        send_code(8'h75);
        push_ev(EV_REFUND, 25);
        send_coin(25, 1'b1);
        n_checks++;
        if (refund_valid !== 1'b1 || usd_refund !== 12'd25) begin
            n_errors++;
            $display("FAIL cancel_with_coin: got refund=%b amount=%0d, required 1 25", refund_valid, usd_refund);
        end
        step();
        step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL cancel_pending: got %0d pending events, required 0", exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int n;
        send_code(8'h75);
        send_coin(25, 1'b0);
        push_ev(EV_REFUND, 25);
        push_ev(EV_TIMEOUT, 0);
        n = 0;
        while (timeout_flag !== 1'b1 && n < TIMEOUT_CYC + 10) begin
            step();
            n++;
        end
        n_checks++;
        if (n != TIMEOUT_CYC) begin
            n_errors++;
            $display("FAIL timeout_cycles: got %0d idle cycles, required %0d", n, TIMEOUT_CYC);
        end
        n_checks++;
        if (refund_valid !== 1'b1 || usd_refund !== 12'd25) begin
            n_errors++;
            $display("FAIL timeout_refund: got refund=%b amount=%0d, required 1 25", refund_valid, usd_refund);
        end
        step();
        step();
        n_checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL timeout_end: got busy=%b pending=%0d, required 0 0", busy, exp_q.size());
        end
    endtask

    task automatic test_same_cycle_and_saturation();
        send_code(8'h75);
        push_ev(EV_VEND, 1);
        push_ev(EV_REFUND, 25);
        send_coin(100, 1'b1);
        n_checks++;
        if (vend !== 1'b1 || vend_slot !== 3'd1) begin
            n_errors++;
            $display("FAIL cancel_coin_vend: got vend=%b slot=%0d, required 1 1", vend, vend_slot);
        end
        step();
        n_checks++;
        if (refund_valid !== 1'b1 || usd_refund !== 12'd25) begin
            n_errors++;
            $display("FAIL cancel_coin_change: got refund=%b amount=%0d, required 1 25", refund_valid, usd_refund);
        end
        step();
        cfg_write(6, 8'h5A, 4095, 15);
        send_code(8'h5A);
        send_coin(10, 1'b0);
        n_checks++;
        if (credit !== 12'd10) begin
            n_errors++;
            $display("FAIL sat_first: got credit=%0d, required 10", credit);
        end
        push_ev(EV_VEND, 6);
        send_coin(4095, 1'b0);
        n_checks++;
        if (credit !== 12'd4095 || vend !== 1'b1) begin
            n_errors++;
            $display("FAIL sat_credit: got credit=%0d vend=%b, required 4095 1", credit, vend);
        end
        step();
        n_checks++;
        if (busy !== 1'b0 || refund_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL sat_no_change: got busy=%b refund=%b, required 0 0", busy, refund_valid);
        end
        step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL sat_pending: got %0d pending events, required 0", exp_q.size());
        end
    endtask

    task automatic test_table_rules();
        do_reset();
        cfg_write(1, 8'h33, 0, 15);
        cfg_write(2, 8'h33, 30, 15);
        cfg_write(5, 8'h33, 60, 15);
        send_code(8'h33);
        n_checks++;
        if (price !== 12'd30 || code_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL lowest_index: got price=%0d valid=%b, required 30 1", price, code_valid);
        end
        // Writes and codes during PAY are ignored.
        cfg_write(2, 8'h33, 99, 15);
        send_code(8'hFF);
        n_checks++;
        if (price !== 12'd30 || code_valid !== 1'b1 || code_invalid !== 1'b0) begin
            n_errors++;
            $display("FAIL pay_ignores: got price=%0d valid=%b invalid=%b, required 30 1 0",
                     price, code_valid, code_invalid);
        end
        push_ev(EV_REFUND, 0);
        send_cancel();
        step();
        // Write racing a lookup in IDLE is dropped.
        cfg_we     = 1'b1;
        cfg_idx    = 3'd2;
        cfg_code   = 8'h33;
        cfg_price  = 12'd99;
        code       = 8'h33;
        code_ready = 1'b1;
        step();
        cfg_we     = 1'b0;
        code_ready = 1'b0;
        push_ev(EV_REFUND, 0);
        send_cancel();
        step();
        send_code(8'h33);
        n_checks++;
        if (price !== 12'd30) begin
            n_errors++;
            $display("FAIL race_write_dropped: got price=%0d, required 30", price);
        end
        push_ev(EV_REFUND, 0);
        send_cancel();
        step();
        // Disabling idx2 takes effect for the very next lookup.
        cfg_write(2, 8'h33, 0, 15);
        send_code(8'h33);
        n_checks++;
        if (price !== 12'd60) begin
            n_errors++;
            $display("FAIL disable_entry: got price=%0d, required 60", price);
        end
        push_ev(EV_VEND, 5);
        send_coin(60, 1'b0);
        n_checks++;
        if (vend !== 1'b1 || vend_slot !== 3'd5) begin
            n_errors++;
            $display("FAIL disable_vend: got vend=%b slot=%0d, required 1 5", vend, vend_slot);
        end
        step();
        step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL table_pending: got %0d pending events, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        send_code(8'h33);
        push_ev(EV_VEND, 5);
        send_coin(60, 1'b0);
        // Coin arriving while vending is rejected, not credited.
        push_ev(EV_REJECT, 0);
        send_coin(10, 1'b0);
        n_checks++;
        if (coin_reject !== 1'b1 || credit !== 12'd0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL vend_reject: got reject=%b credit=%0d busy=%b, required 1 0 0",
                     coin_reject, credit, busy);
        end
        send_code(8'h33);
        n_checks++;
        if (code_valid !== 1'b1 || price !== 12'd60) begin
            n_errors++;
            $display("FAIL b2b_select: got valid=%b price=%0d, required 1 60", code_valid, price);
        end
        send_coin(20, 1'b0);
        // Reset mid-purchase discards credit without a refund pulse.
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        n_checks++;
        if (credit !== 12'd0 || busy !== 1'b0 || refund_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid: got credit=%0d busy=%b refund=%b, required 0 0 0",
                     credit, busy, refund_valid);
        end
        step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL b2b_pending: got %0d pending events, required 0", exp_q.size());
        end
    endtask

`ifdef STOCK_COUNT_EN
    task automatic test_stock();
        do_reset();
        cfg_write(4, 8'hC1, 10, 1);
        send_code(8'hC1);
        push_ev(EV_VEND, 4);
        send_coin(10, 1'b0);
        n_checks++;
        if (vend !== 1'b1 || vend_slot !== 3'd4) begin
            n_errors++;
            $display("FAIL stock_vend: got vend=%b slot=%0d, required 1 4", vend, vend_slot);
        end
        step();
        push_ev(EV_INVALID, 0);
        push_ev(EV_SOLDOUT, 0);
        send_code(8'hC1);
        n_checks++;
        if (sold_out !== 1'b1 || code_invalid !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL stock_soldout: got sold_out=%b invalid=%b busy=%b, required 1 1 0",
                     sold_out, code_invalid, busy);
        end
        step();
        step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL stock_pending: got %0d pending events, required 0", exp_q.size());
        end
    endtask
`endif

    initial begin
        reset      = 1'b1;
        code       = '0;
        code_ready = 1'b0;
        coin       = '0;
        coin_ready = 1'b0;
        cancel     = 1'b0;
        cfg_we     = 1'b0;
        cfg_idx    = '0;
        cfg_code   = '0;
        cfg_price  = '0;
        cfg_stock  = '0;
        step();

        test_reset();
        test_basic_purchase();
        test_change();
        test_invalid_reject();
        test_cancel();
        test_timeout();
        test_same_cycle_and_saturation();
        test_table_rules();
        test_back_to_back();
`ifdef STOCK_COUNT_EN
        test_stock();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
